multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Multicycle MIPS controller that sequences the shared datapath (one memory, one ALU) across several cycles per instruction. It replaces the single-cycle combinational control. It drives mux selects and write enables per state. Each memory access waits on a memReady handshake. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

Parameters:
None. Opcode and state constants live in the shared package.

Ports:
clk  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
op  input  6  instruction opcode, from the instruction register
funct  input  6  R-type function field
zero  input  1  ALU zero flag
memReady  input  1  memory completes the current access this cycle
memRead  output  1  memory read request
memWrite  output  1  memory write request
iOrD  output  1  memory address select: 0=PC, 1=ALUOut
irWrite  output  1  instruction register load
pcWrite  output  1  PC load (unconditional OR branch-taken)
pcSource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
aluSrcA  output  1  ALU A select: 0=PC, 1=regA
aluSrcB  output  2  ALU B select: 00=regB, 01=const 4, 10=signImm, 11=signImm<<2
aluControl  output  3  ALU operation
regDst  output  1  register write address select: 0=rt, 1=rd
memToReg  output  1  register write data select: 0=ALUOut, 1=MDR
regWrite  output  1  register file write enable
illegalOp  output  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- 4-bit state register, async reset to FETCH. While resetN=0 every output is forced to 0.
- Outputs are Moore (decoded from state) with two exceptions:
  - pcWrite/irWrite in FETCH are qualified by memReady.
  - pcWrite in BRANCH is qualified by zero.
- aluOp per state: 00=add, 01=sub, 10=funct. aluControl is derived from aluOp and funct:
  - aluOp 00 -> 010; aluOp 01 -> 110.
  - aluOp 10 -> funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
- FETCH: memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - memReady=0: stay in FETCH; irWrite=pcWrite=0.
  - memReady=1: irWrite=1, pcWrite=1, go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target computed into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op: illegalOp=1 for this cycle, go to FETCH.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: memRead=1, iOrD=1. Hold until memReady=1, then go to MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1 -> FETCH.
- MEMWR: memWrite=1, iOrD=1. Hold until memReady=1, then go to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSource=01, pcWrite=zero -> FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00 -> ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0 -> FETCH.
- JUMP: pcSource=10, pcWrite=1 -> FETCH.
- Latency with memReady held at 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - Each memReady=0 cycle in a memory state adds 1 cycle.
- memRead and memWrite stay asserted continuously (level) for the whole wait. Request signals never drop while waiting.
- op/funct are sampled only in DECODE, EXEC and MEMADR. The IR holds them stable after FETCH.
- Reset mid-operation, including a pending MEMWR: outputs drop to 0 immediately (asynchronously); the FSM restarts in FETCH on the first clock edge after release.
- Unused state encodings (12-15) go to FETCH on the next edge with all outputs 0.

Decomposition:
- Package multicycle_pkg holds:
  - state enum (FETCH=0 ... JUMP=11)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - aluOp constants and funct constants
- One sub-module, mc_alu_decoder: combinational aluOp+funct -> aluControl, kept separate so the bench can check it exhaustively.
- The FSM (state register, next-state logic, output decode) stays in the top module.

Test Plan:
- lw (op=100011), memReady=1: states F,D,MA,MR,MWB. regWrite=1 and memToReg=1 only in cycle 5; returns to FETCH in cycle 6.
- sw (op=101011), memReady held 0 for 2 cycles in MEMWR: memWrite=1, iOrD=1 for 3 cycles. regWrite never asserts. Total 6 cycles.
- beq (op=000100) run twice, zero=1 then zero=0: pcWrite=1 with pcSource=01 in cycle 3 for the first run, 0 for the second. aluControl=110 in BRANCH.
- R-type sub (funct=100010): aluControl=110 in EXEC; then regWrite=1, regDst=1 in ALUWB. slt (funct=101010) gives aluControl=111.
- FETCH with memReady=0 for 3 cycles: irWrite=pcWrite=0, memRead=1 throughout. In the 4th cycle memReady=1 gives irWrite=pcWrite=1.
- Two exception cases:
  - op=111111: illegalOp pulses exactly 1 cycle in DECODE, then FETCH.
  - resetN=0 during MEMWR: memWrite drops to 0 without waiting for a clock edge; FETCH is entered after release.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation classes, R-type function codes and ALU control encodings.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath side.
interface multicycle_control_fsm_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic       memRead;
  logic       memWrite;
  logic       iOrD;
  logic       irWrite;
  logic       pcWrite;
  logic [1:0] pcSource;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       illegalOp;

  modport master (
    input  op, funct, zero, memReady,
    output memRead, memWrite, iOrD, irWrite, pcWrite, pcSource,
           aluSrcA, aluSrcB, aluControl, regDst, memToReg, regWrite, illegalOp
  );

  modport slave (
    output op, funct, zero, memReady,
    input  memRead, memWrite, iOrD, irWrite, pcWrite, pcSource,
           aluSrcA, aluSrcB, aluControl, regDst, memToReg, regWrite, illegalOp
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps the controller's aluOp class and the
// R-type funct field onto the 3-bit ALU operation.
module mc_alu_decoder
  import multicycle_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          default:   alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: sequences a shared memory/ALU datapath through
// FETCH..writeback states, waiting on memReady for every memory access.
module multicycle_control_fsm
  import multicycle_pkg::*;
(
  input  logic                          clk,
  input  logic                          resetN,
  multicycle_control_fsm_if.master      bus
);

  state_t     state_q, state_d;
  alu_op_t    alu_op_c;
  logic       state_valid_c;
  logic       out_en;
  logic       mem_read_c, mem_write_c, i_or_d_c, ir_write_c, pc_write_c;
  logic [1:0] pc_source_c, alu_src_b_c;
  logic       alu_src_a_c, reg_dst_c, mem_to_reg_c, reg_write_c, illegal_op_c;
  logic [2:0] alu_control_c;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    state_valid_c = 1'b1;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    i_or_d_c      = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    pc_source_c   = 2'b00;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'b00;
    alu_op_c      = ALUOP_ADD;
    reg_dst_c     = 1'b0;
    mem_to_reg_c  = 1'b0;
    reg_write_c   = 1'b0;
    illegal_op_c  = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (bus.memReady) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        // Branch target (PC + signImm<<2) is precomputed into ALUOut here.
        alu_src_b_c = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal_op_c = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (bus.memReady) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (bus.memReady) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_SUB;
        pc_source_c = 2'b01;
        pc_write_c  = bus.zero;
        state_d     = FETCH;
      end
      ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_source_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = FETCH;
      end
      default: begin
        state_valid_c = 1'b0;
        state_d       = FETCH;
      end
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_c),
    .funct_i       (bus.funct),
    .alu_control_o (alu_control_c)
  );

  // Outputs drop asynchronously under reset and stay quiet in unused encodings.
  assign out_en = resetN & state_valid_c;

  assign bus.memRead    = out_en & mem_read_c;
  assign bus.memWrite   = out_en & mem_write_c;
  assign bus.iOrD       = out_en & i_or_d_c;
  assign bus.irWrite    = out_en & ir_write_c;
  assign bus.pcWrite    = out_en & pc_write_c;
  assign bus.pcSource   = {2{out_en}} & pc_source_c;
  assign bus.aluSrcA    = out_en & alu_src_a_c;
  assign bus.aluSrcB    = {2{out_en}} & alu_src_b_c;
  assign bus.aluControl = {3{out_en}} & alu_control_c;
  assign bus.regDst     = out_en & reg_dst_c;
  assign bus.memToReg   = out_en & mem_to_reg_c;
  assign bus.regWrite   = out_en & reg_write_c;
  assign bus.illegalOp  = out_en & illegal_op_c;

endmodule
